mult_div: RTL

MULT_DIV -- requirements
Module: mult_div

---
 rtl/mult_div.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mult_div.sv
// mult_div: 32-bit signed radix-2 Booth multiplier / restoring divider, one bit per cycle; MULT_DIV_ZERO_EXC_EN adds divide-by-zero detection.
// done 33 cycles after start (2 for a trapped b=0 DIV); start and operand changes are ignored while busy.
module mult_div (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [33:0] acc_q, acc_d;
  logic [31:0] qr_q, qr_d;
  logic        qm1_q, qm1_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
`ifdef MULT_DIV_ZERO_EXC_EN
  logic        dz_q, dz_d;
`endif

  // Booth step: acc is two bits wider than an operand so A - (-2^31) cannot overflow.
  logic [33:0] m_ext, booth_sum, booth_acc;
  logic [31:0] booth_qr;
  always_comb begin
    m_ext = {{2{b_q[31]}}, b_q};
    case ({qr_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase
    booth_acc = {booth_sum[33], booth_sum[33:1]};
    booth_qr  = {booth_sum[0], qr_q[31:1]};
  end

  logic [31:0] dvs, div_qr, q_fix, r_fix;
  logic [32:0] trial;
  logic [33:0] diff, div_acc;
  always_comb begin
    dvs   = b_q[31] ? -b_q : b_q;
    trial = {acc_q[31:0], qr_q[31]};
    diff  = {1'b0, trial} - {2'b00, dvs};
    if (!diff[33]) begin
      div_acc = diff;
      div_qr  = {qr_q[30:0], 1'b1};
    end else begin
      div_acc = {1'b0, trial};
      div_qr  = {qr_q[30:0], 1'b0};
    end
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    q_fix = (a_q[31] ^ b_q[31]) ? -div_qr : div_qr;
    r_fix = a_q[31] ? -div_acc[31:0] : div_acc[31:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    qr_d    = qr_q;
    qm1_d   = qm1_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MULT_DIV_ZERO_EXC_EN
    dz_d    = dz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          cnt_d   = 5'd0;
          acc_d   = 34'd0;
          qm1_d   = 1'b0;
          qr_d    = (op && a[31]) ? -a : a;
          state_d = op ? S_DIV : S_MULT;
`ifdef MULT_DIV_ZERO_EXC_EN
          dz_d    = op && (b == 32'd0);
`endif
        end
      end
      S_MULT: begin
        acc_d = booth_acc;
        qr_d  = booth_qr;
        qm1_d = qr_q[0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_DONE;
          hi_d    = booth_acc[31:0];
          lo_d    = booth_qr;
        end
      end
      S_DIV: begin
`ifdef MULT_DIV_ZERO_EXC_EN
        if (dz_q) begin
          state_d = S_DONE;
        end else begin
`else
        begin
`endif
          acc_d = div_acc;
          qr_d  = div_qr;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = S_DONE;
            hi_d    = r_fix;
            lo_d    = q_fix;
`ifndef MULT_DIV_ZERO_EXC_EN
            if (b_q == 32'd0) begin
              hi_d = a_q;
              lo_d = 32'hFFFF_FFFF;
            end
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      acc_q   <= 34'd0;
      qr_q    <= 32'd0;
      qm1_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
`ifdef MULT_DIV_ZERO_EXC_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      qr_q    <= qr_d;
      qm1_q   <= qm1_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MULT_DIV_ZERO_EXC_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;
`ifdef MULT_DIV_ZERO_EXC_EN
  assign div_zero = done && dz_q;
`else
  assign div_zero = 1'b0;
`endif

endmodule
